// File: rtl/demux_1_to_2_reg_if.sv
// -----------------------------------------------------------------------------
// demux_1_to_2_reg_if
// Handshake bundle for the registered 1-to-2 demultiplexer.
//
// Signals:
//   demux_input  word to route            (producer -> demux)
//   demux_sel    destination select       (producer -> demux)
//   in_valid     input word valid         (producer -> demux)
//   in_ready     selected channel ready   (demux -> producer)
//   demux_out_0  channel 0 held word      (demux -> consumer 0)
//   out0_valid   channel 0 holds a word   (demux -> consumer 0)
//   out0_ready   consumer 0 takes word    (consumer 0 -> demux)
//   demux_out_1  channel 1 held word      (demux -> consumer 1)
//   out1_valid   channel 1 holds a word   (demux -> consumer 1)
//   out1_ready   consumer 1 takes word    (consumer 1 -> demux)
//
// Modports:
//   slave  - the demultiplexer itself
//   master - the surrounding producer/consumers
// -----------------------------------------------------------------------------
interface demux_1_to_2_reg_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] demux_input;
   logic                  demux_sel;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] demux_out_0;
   logic                  out0_valid;
   logic                  out0_ready;
   logic [DATA_WIDTH-1:0] demux_out_1;
   logic                  out1_valid;
   logic                  out1_ready;

   modport slave (
      input  demux_input, demux_sel, in_valid, out0_ready, out1_ready,
      output in_ready, demux_out_0, out0_valid, demux_out_1, out1_valid
   );

   modport master (
      output demux_input, demux_sel, in_valid, out0_ready, out1_ready,
      input  in_ready, demux_out_0, out0_valid, demux_out_1, out1_valid
   );
endinterface

// File: rtl/demux_1_to_2_reg.sv
// -----------------------------------------------------------------------------
// demux_1_to_2_reg
// Registered 1-to-2 demultiplexer. Steers one bus word into one of two
// 1-entry holding registers, each with its own valid/ready handshake, so a
// stalled consumer never blocks traffic to the other one.
//
// Ports:
//   clk           rising-edge clock
//   clr           synchronous active-low reset
//   bus           demux_1_to_2_reg_if.slave handshake bundle
//   xfer_count_0  channel 0 accept count (only with DEMUX_COUNT_EN)
//   xfer_count_1  channel 1 accept count (only with DEMUX_COUNT_EN)
//
// Optional feature macro: DEMUX_COUNT_EN adds the COUNT_WIDTH parameter and
// two wrapping per-channel accept counters. Without it they are absent.
// -----------------------------------------------------------------------------
module demux_1_to_2_reg #(
   parameter int DATA_WIDTH = 32
`ifdef DEMUX_COUNT_EN
   , parameter int COUNT_WIDTH = 16
`endif
) (
   input  logic                   clk,
   input  logic                   clr,
   demux_1_to_2_reg_if.slave      bus
`ifdef DEMUX_COUNT_EN
   , output logic [COUNT_WIDTH-1:0] xfer_count_0
   , output logic [COUNT_WIDTH-1:0] xfer_count_1
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   chan_state_t           state_0;
   chan_state_t           state_1;
   logic [DATA_WIDTH-1:0] data_0;
   logic [DATA_WIDTH-1:0] data_1;

   logic accept_0;
   logic accept_1;
   logic drain_0;
   logic drain_1;

   assign bus.out0_valid  = (state_0 == FULL);
   assign bus.out1_valid  = (state_1 == FULL);
   assign bus.demux_out_0 = data_0;
   assign bus.demux_out_1 = data_1;

   // Ready follows the selected channel only; a full channel still accepts
   // when its consumer drains on the same edge (combinational ready path).
   always_comb begin
      bus.in_ready = 1'b0;
      if (bus.demux_sel) begin
         bus.in_ready = (state_1 == EMPTY) || bus.out1_ready;
      end else begin
         bus.in_ready = (state_0 == EMPTY) || bus.out0_ready;
      end
   end

   always_comb begin
      accept_0 = bus.in_valid && bus.in_ready && !bus.demux_sel;
      accept_1 = bus.in_valid && bus.in_ready &&  bus.demux_sel;
      drain_0  = (state_0 == FULL) && bus.out0_ready;
      drain_1  = (state_1 == FULL) && bus.out1_ready;
   end

   // Holding registers: an accept wins over a drain, so a simultaneous
   // drain and refill keeps the channel FULL with the new word.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_0 <= EMPTY;
         state_1 <= EMPTY;
         data_0  <= '0;
         data_1  <= '0;
      end else begin
         if (accept_0) begin
            data_0  <= bus.demux_input;
            state_0 <= FULL;
         end else if (drain_0) begin
            state_0 <= EMPTY;
         end

         if (accept_1) begin
            data_1  <= bus.demux_input;
            state_1 <= FULL;
         end else if (drain_1) begin
            state_1 <= EMPTY;
         end
      end
   end

`ifdef DEMUX_COUNT_EN
   // Accept counters wrap naturally at 2^COUNT_WIDTH.
   always_ff @(posedge clk) begin
      if (!clr) begin
         xfer_count_0 <= '0;
         xfer_count_1 <= '0;
      end else begin
         if (accept_0) xfer_count_0 <= xfer_count_0 + 1'b1;
         if (accept_1) xfer_count_1 <= xfer_count_1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_demux_1_to_2_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1_to_2_reg
// Self-checking bench for demux_1_to_2_reg: a directed vector table, a
// randomized run against a channel-array reference model, and (with
// DEMUX_COUNT_EN) a counter wrap sequence.
// -----------------------------------------------------------------------------
module tb_demux_1_to_2_reg;

   localparam int DW = 32;

   logic clk;
   logic clr;

   demux_1_to_2_reg_if #(.DATA_WIDTH(DW)) bus ();

`ifdef DEMUX_COUNT_EN
   logic [15:0] xfer_count_0;
   logic [15:0] xfer_count_1;
`endif

   demux_1_to_2_reg #(.DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .clr          (clr),
      .bus          (bus.slave)
`ifdef DEMUX_COUNT_EN
      , .xfer_count_0 (xfer_count_0)
      , .xfer_count_1 (xfer_count_1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total_checks;
   int passed_checks;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_checks++;
      if (act === exp) begin
         passed_checks++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic iv, input logic s,
                        input logic [DW-1:0] d, input logic r0, input logic r1);
      clr             = c;
      bus.in_valid    = iv;
      bus.demux_sel   = s;
      bus.demux_input = d;
      bus.out0_ready  = r0;
      bus.out1_ready  = r1;
   endtask

   typedef struct {
      logic          c;
      logic          iv;
      logic          s;
      logic [DW-1:0] d;
      logic          r0;
      logic          r1;
      logic          exp_rdy;
      logic          exp_v0;
      logic [DW-1:0] exp_d0;
      logic          exp_v1;
      logic [DW-1:0] exp_d1;
   } vec_t;

   vec_t vecs[10];

   // Reference model: one entry per channel, indexed by select value.
   logic          m_v[2];
   logic [DW-1:0] m_d[2];
   logic [15:0]   m_cnt[2];

   initial begin
      total_checks  = 0;
      passed_checks = 0;

      //             clr iv sel data           r0 r1 rdy v0 d0            v1 d1
      vecs[0] = '{1'b0,1'b1,1'b0,32'h11111111,1'b0,1'b0, 1'b1, 1'b0,32'h0,        1'b0,32'h0};
      vecs[1] = '{1'b0,1'b1,1'b1,32'h22222222,1'b1,1'b0, 1'b1, 1'b0,32'h0,        1'b0,32'h0};
      vecs[2] = '{1'b1,1'b1,1'b0,32'hDEADBEEF,1'b0,1'b0, 1'b1, 1'b1,32'hDEADBEEF, 1'b0,32'h0};
      vecs[3] = '{1'b1,1'b1,1'b0,32'hCAFEF00D,1'b0,1'b0, 1'b0, 1'b1,32'hDEADBEEF, 1'b0,32'h0};
      vecs[4] = '{1'b1,1'b1,1'b0,32'h12345678,1'b1,1'b0, 1'b1, 1'b1,32'h12345678, 1'b0,32'h0};
      vecs[5] = '{1'b1,1'b1,1'b1,32'hA5A5A5A5,1'b0,1'b0, 1'b1, 1'b1,32'h12345678, 1'b1,32'hA5A5A5A5};
      vecs[6] = '{1'b0,1'b1,1'b1,32'hFFFFFFFF,1'b0,1'b0, 1'b0, 1'b0,32'h0,        1'b0,32'h0};
      vecs[7] = '{1'b1,1'b1,1'b1,32'h00000001,1'b0,1'b0, 1'b1, 1'b0,32'h0,        1'b1,32'h00000001};
      vecs[8] = '{1'b1,1'b0,1'b0,32'h00000077,1'b0,1'b1, 1'b1, 1'b0,32'h0,        1'b0,32'h00000001};
      vecs[9] = '{1'b1,1'b0,1'b1,32'h00000099,1'b0,1'b0, 1'b1, 1'b0,32'h0,        1'b0,32'h00000001};

      // Bring state out of X before the table starts.
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Directed table: ready checked before the edge, registers after it.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].c, vecs[i].iv, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1);
         #1;
         chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_rdy));
         @(posedge clk); #1;
         chk($sformatf("vec%0d out0_valid", i), 64'(bus.out0_valid), 64'(vecs[i].exp_v0));
         chk($sformatf("vec%0d demux_out_0", i), 64'(bus.demux_out_0), 64'(vecs[i].exp_d0));
         chk($sformatf("vec%0d out1_valid", i), 64'(bus.out1_valid), 64'(vecs[i].exp_v1));
         chk($sformatf("vec%0d demux_out_1", i), 64'(bus.demux_out_1), 64'(vecs[i].exp_d1));
      end

      // Randomized run; first cycle is forced into reset to align the model.
      for (int n = 0; n < 2000; n++) begin
         logic          c, iv, s, r0, r1, exp_rdy, acc;
         logic [DW-1:0] d;
         logic          rr[2];
         c  = (n == 0) ? 1'b0 : ($urandom_range(31) != 0);
         iv = $urandom_range(3) != 0;
         s  = $urandom_range(1);
         d  = $urandom;
         r0 = $urandom_range(2) == 0;
         r1 = $urandom_range(1);
         rr[0] = r0;
         rr[1] = r1;
         drive(c, iv, s, d, r0, r1);
         #1;
         if (n != 0) begin
            exp_rdy = !m_v[s] || rr[s];
            chk("rand in_ready", 64'(bus.in_ready), 64'(exp_rdy));
         end else begin
            exp_rdy = 1'b0;
         end
         @(posedge clk); #1;
         if (!c) begin
            for (int k = 0; k < 2; k++) begin
               m_v[k]   = 1'b0;
               m_d[k]   = '0;
               m_cnt[k] = '0;
            end
         end else begin
            acc = iv && exp_rdy;
            for (int k = 0; k < 2; k++) begin
               if (acc && (int'(s) == k)) begin
                  m_v[k]   = 1'b1;
                  m_d[k]   = d;
                  m_cnt[k] = m_cnt[k] + 16'd1;
               end else if (m_v[k] && rr[k]) begin
                  m_v[k] = 1'b0;
               end
            end
         end
         chk("rand out0_valid", 64'(bus.out0_valid), 64'(m_v[0]));
         chk("rand demux_out_0", 64'(bus.demux_out_0), 64'(m_d[0]));
         chk("rand out1_valid", 64'(bus.out1_valid), 64'(m_v[1]));
         chk("rand demux_out_1", 64'(bus.demux_out_1), 64'(m_d[1]));
`ifdef DEMUX_COUNT_EN
         chk("rand xfer_count_0", 64'(xfer_count_0), 64'(m_cnt[0]));
         chk("rand xfer_count_1", 64'(xfer_count_1), 64'(m_cnt[1]));
`endif
      end

`ifdef DEMUX_COUNT_EN
      // Counter wrap: 65537 accepts into channel 0 leave the count at 1.
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("cnt reset 0", 64'(xfer_count_0), 64'd0);
      chk("cnt reset 1", 64'(xfer_count_1), 64'd0);
      for (int n = 0; n < 65537; n++) begin
         drive(1'b1, 1'b1, 1'b0, DW'(n), 1'b1, 1'b0);
         @(posedge clk); #1;
      end
      chk("cnt wrap 0", 64'(xfer_count_0), 64'd1);
      chk("cnt wrap 1", 64'(xfer_count_1), 64'd0);
      chk("cnt wrap data", 64'(bus.demux_out_0), 64'd65536);
`endif

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
